// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: branch redirect, load-use bubble and memory-freeze control with perf counters
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             ex_valid,
  input  logic             ex_npc_op,
  input  logic [31:0]      ex_npc_bj,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic             misalign_err,
  output logic [CNT_W-1:0] cnt_redirect,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [1:0]       ctrl_state
);
  typedef enum logic [1:0] {RUN = 2'b00, LU_STALL = 2'b01} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_redirect_q, cnt_stall_q;
  logic             misalign_q;
  logic             taken, lu, bubble, go, legal;
  always_comb begin
    go      = ~cpu_rst;
    taken   = ex_valid & ex_npc_op & ~mem_busy;
    lu      = ex_valid & ex_is_load & id_valid & (ex_rd != 5'd0) &
              ((id_re1 & (id_rs1 == ex_rd)) | (id_re2 & (id_rs2 == ex_rd)));
    bubble  = (state_q == RUN) & lu & ~taken & ~mem_busy;
    legal   = (state_q == RUN) | (state_q == LU_STALL);
    // a frozen pipe holds its state; an unused encoding falls back to RUN
    state_d = (mem_busy & legal) ? state_q : bubble ? LU_STALL : RUN;
  end
  assign pc_redirect  = go & taken;
  assign pc_target    = (go & taken) ? ex_npc_bj : 32'h0;
  assign pc_stall     = go & bubble;
  assign ifid_stall   = go & bubble;
  assign ifid_flush   = go & taken;
  assign idex_flush   = go & (taken | bubble);
  assign pipe_freeze  = go & mem_busy;
  assign misalign_err = misalign_q;
  assign cnt_redirect = cnt_redirect_q;
  assign cnt_stall    = cnt_stall_q;
  assign ctrl_state   = state_q;
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q        <= RUN;
      cnt_redirect_q <= '0;
      cnt_stall_q    <= '0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_redirect_q <= cnt_clr ? '0 : cnt_redirect_q + CNT_W'(taken);
      cnt_stall_q    <= cnt_clr ? '0 : cnt_stall_q + CNT_W'(bubble);
      misalign_q     <= misalign_q | (taken & (ex_npc_bj[1:0] != 2'b00));
    end
  end
endmodule
